reg_mem: RTL and testbench

Parameterised single-port register-file memory, DEPTH = 2^ADDR_BITS words of DATA_WIDTH bits, built from flip-flops rather than an inferred RAM macro. Writes are synchronous when wen is high. Reads are registered, with one clock of latency. Used as the general-purpose data and register store of the simple CPU datapath.

---
 rtl/reg_mem.sv | 45 ++++
 tb/tb_reg_mem.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_mem.sv
// reg_mem: flip-flop based single-port register file with registered read data.
// A write also forwards data_in to data_out on the same edge.
// Reset clears every word and the output register asynchronously.
module reg_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 5
) (
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rst
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [DATA_WIDTH-1:0] r_data_out;

  // Storage array: cleared on reset, written on wen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wen) begin
      r_mem[addr] <= data_in;
    end
  end

  // Output register: write-through on a write, stored word on a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (wen) begin
      r_data_out <= data_in;
    end else begin
      r_data_out <= r_mem[addr];
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_reg_mem.sv
// Self-checking bench for reg_mem: vector table, wrap-around sweep, async reset,
// randomized traffic against a behavioural model, and a 16x8 parameter variant.
module tb_reg_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       wen = 1'b0;
  logic [7:0] data_out;

  logic [2:0]  p_addr = '0;
  logic [15:0] p_data_in = '0;
  logic        p_wen = 1'b0;
  logic [15:0] p_data_out;

  int checks = 0;
  int failures = 0;

  reg_mem dut (
    .addr     (addr),
    .data_in  (data_in),
    .wen      (wen),
    .clk      (clk),
    .data_out (data_out),
    .rst      (rst)
  );

  reg_mem #(
    .DATA_WIDTH (16),
    .ADDR_BITS  (3)
  ) dut_p (
    .addr     (p_addr),
    .data_in  (p_data_in),
    .wen      (p_wen),
    .clk      (clk),
    .data_out (p_data_out),
    .rst      (rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wen;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Behavioural model: plain array plus the last value presented at the output.
  logic [7:0] model_mem [32];
  logic [7:0] model_out;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_op(input logic w, input logic [4:0] a, input logic [7:0] d);
    if (w) begin
      model_mem[a] = d;
      model_out = d;
    end else begin
      model_out = model_mem[a];
    end
  endtask

  // Last data value i in 10..42 whose (i+2) mod 32 lands on address a.
  function automatic logic [7:0] sweep_exp(input int a);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 10; i <= 42; i++) begin
      if (((i + 2) % 32) == a) v = 8'(i);
    end
    return v;
  endfunction

  initial begin
    logic [5:0] wide;
    logic [3:0] pwide;

    vecs[0] = '{1'b0, 5'd0,  8'h00, 8'h00};
    vecs[1] = '{1'b0, 5'd5,  8'h00, 8'h00};
    vecs[2] = '{1'b0, 5'd31, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 5'd3,  8'hA5, 8'hA5};
    vecs[4] = '{1'b0, 5'd3,  8'h00, 8'hA5};
    vecs[5] = '{1'b1, 5'd0,  8'h01, 8'h01};
    vecs[6] = '{1'b1, 5'd1,  8'h02, 8'h02};
    vecs[7] = '{1'b0, 5'd0,  8'h00, 8'h01};
    vecs[8] = '{1'b0, 5'd1,  8'h00, 8'h02};
    vecs[9] = '{1'b0, 5'd31, 8'h00, 8'h00};

    // Reset state.
    #1;
    check("reset_out", {8'h00, data_out}, 16'h0000);
    check("reset_out_p", p_data_out, 16'h0000);
    #11;
    rst = 1'b0;

    // Vector table.
    for (int k = 0; k < 10; k++) begin
      wen = vecs[k].wen;
      addr = vecs[k].addr;
      data_in = vecs[k].din;
      step();
      check($sformatf("vec%0d", k), {8'h00, data_out}, {8'h00, vecs[k].exp});
    end

    // Wrap-around sweep: writes to (i+2) truncated onto 5 bits.
    for (int i = 10; i <= 42; i++) begin
      wide = 6'(i + 2);
      wen = 1'b1;
      addr = wide[4:0];
      data_in = 8'(i);
      step();
    end
    wen = 1'b0;
    for (int a = 0; a < 32; a++) begin
      addr = 5'(a);
      step();
      check($sformatf("sweep_a%0d", a), {8'h00, data_out}, {8'h00, sweep_exp(a)});
      if (a == 12) check("sweep_a12_overwrite", {8'h00, data_out}, 16'd42);
      if (a == 0)  check("sweep_a0", {8'h00, data_out}, 16'd30);
      if (a == 31) check("sweep_a31", {8'h00, data_out}, 16'd29);
      if (a == 13) check("sweep_a13", {8'h00, data_out}, 16'd11);
      if (a == 11) check("sweep_a11", {8'h00, data_out}, 16'd41);
    end

    // Asynchronous reset between edges.
    wen = 1'b1;
    addr = 5'd7;
    data_in = 8'h3C;
    step();
    check("async_pre", {8'h00, data_out}, 16'h003C);
    #2;
    rst = 1'b1;
    #1;
    check("async_immediate", {8'h00, data_out}, 16'h0000);
    data_in = 8'hFF;
    step();
    check("async_edge_in_reset", {8'h00, data_out}, 16'h0000);
    rst = 1'b0;
    wen = 1'b0;
    addr = 5'd7;
    step();
    check("async_read7", {8'h00, data_out}, 16'h0000);

    // Randomized traffic against the model (memory is all zero after reset).
    for (int a = 0; a < 32; a++) model_mem[a] = 8'h00;
    model_out = 8'h00;
    for (int n = 0; n < 300; n++) begin
      wen = 1'($urandom_range(0, 1));
      addr = 5'($urandom);
      data_in = 8'($urandom);
      model_op(wen, addr, data_in);
      step();
      check($sformatf("rand%0d", n), {8'h00, data_out}, {8'h00, model_out});
    end
    wen = 1'b0;

    // Parameter variant: 16-bit words, 8 entries.
    p_wen = 1'b1;
    p_addr = 3'd7;
    p_data_in = 16'hBEEF;
    step();
    check("p_write_through", p_data_out, 16'hBEEF);
    p_wen = 1'b0;
    p_data_in = 16'h0000;
    step();
    check("p_read7", p_data_out, 16'hBEEF);
    pwide = 4'd8;
    p_wen = 1'b1;
    p_addr = pwide[2:0];
    p_data_in = 16'h1234;
    step();
    p_wen = 1'b0;
    p_addr = 3'd0;
    step();
    check("p_read0_wrap", p_data_out, 16'h1234);
    p_addr = 3'd7;
    step();
    check("p_read7_kept", p_data_out, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
